// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, fetches from instruction ROM, applies decoder branches, runs one program per req
module fetch_sequencer #(
  parameter int PCW = 10,
  parameter int IW = 9,
  parameter int OFFW = 8,
  parameter int CNTW = 16,
  parameter logic [PCW-1:0] START_PC = '0,
  parameter logic [IW-1:0] HALT_OP = {IW{1'b1}}
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_req,
  input  logic            i_stall,
  input  logic            i_branch,
  input  logic            i_taken,
  input  logic            i_how_high,
  input  logic [PCW-1:0]  i_br_target,
  input  logic [OFFW-1:0] i_br_offset,
  input  logic [IW-1:0]   i_rom_data,
  output logic [PCW-1:0]  o_rom_addr,
  output logic [IW-1:0]   o_instr,
  output logic [PCW-1:0]  o_pc,
  output logic            o_running,
  output logic            o_done,
  output logic [CNTW-1:0] o_icount
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_state_nx;
  logic [PCW-1:0] r_pc, w_pc_nx;
  logic [CNTW-1:0] r_icount, w_cnt_nx;
  logic [PCW-1:0] w_sext;
  logic w_halt;
  assign w_sext = {{(PCW-OFFW){i_br_offset[OFFW-1]}}, i_br_offset};
  assign w_halt = i_rom_data == HALT_OP;
  assign o_rom_addr = r_pc;
  assign o_pc = r_pc;
  assign o_icount = r_icount;
  assign o_running = r_state == RUN;
  assign o_done = r_state == DONE;
  assign o_instr = o_running ? i_rom_data : '0;
  // next state, PC and retired count; HALT outranks any branch, stall outranks everything
  always_comb begin
    w_state_nx = r_state;
    w_pc_nx = r_pc;
    w_cnt_nx = r_icount;
    if (r_state == IDLE && i_req) begin
      w_state_nx = RUN;
      w_pc_nx = START_PC;
      w_cnt_nx = '0;
    end else if (r_state == DONE && !i_req) begin
      w_state_nx = IDLE;
    end else if (r_state == RUN && !i_stall) begin
      w_cnt_nx = &r_icount ? r_icount : r_icount + 1'b1;
      if (w_halt) w_state_nx = DONE;
      else w_pc_nx = !(i_branch && i_taken) ? r_pc + 1'b1 : i_how_high ? i_br_target : r_pc + w_sext;
    end
  end
  // state, PC and counter registers; reset abandons any running program
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_pc <= '0;
      r_icount <= '0;
    end else begin
      r_state <= w_state_nx;
      r_pc <= w_pc_nx;
      r_icount <= w_cnt_nx;
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks of fetch, branching, wrap, stall, reset and counter saturation
module tb_fetch_sequencer;
  logic clk = 0, rst = 1, req = 0, stall = 0, branch = 0, taken = 0, how_high = 0;
  logic [9:0] br_target = '0, rom_addr, pc;
  logic [7:0] br_offset = '0;
  logic [8:0] rom_data, instr;
  logic running, done;
  logic [3:0] icount;
  logic [8:0] rom [0:1023];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];

  fetch_sequencer #(.CNTW(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_req(req), .i_stall(stall), .i_branch(branch),
    .i_taken(taken), .i_how_high(how_high), .i_br_target(br_target), .i_br_offset(br_offset),
    .i_rom_data(rom_data), .o_rom_addr(rom_addr), .o_instr(instr), .o_pc(pc),
    .o_running(running), .o_done(done), .o_icount(icount)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic jump(input logic [9:0] t);
    branch = 1; taken = 1; how_high = 1; br_target = t;
    tick();
    branch = 0; taken = 0; how_high = 0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 9'h000;
    repeat (2) tick();
    chk("rst_pc", pc, 0); chk("rst_run", running, 0); chk("rst_done", done, 0);
    chk("rst_cnt", icount, 0); chk("rst_instr", instr, 0);
    rst = 0;
    tick();
    chk("idle_stay", running, 0);
    rom[0] = 9'h001; rom[1] = 9'h002; rom[2] = 9'h1FF;
    req = 1;
    tick(); chk("t1_i0", instr, 9'h001); chk("t1_run", running, 1);
    tick(); chk("t1_i1", instr, 9'h002);
    tick(); chk("t1_i2", instr, 9'h1FF);
    tick(); chk("t1_done", done, 1); chk("t1_pc", pc, 2); chk("t1_cnt", icount, 3); chk("t1_instr0", instr, 0);
    req = 0;
    tick(); chk("t1_idle_done", done, 0); chk("t1_idle_run", running, 0); chk("t1_cnt_hold", icount, 3);
    rom[2] = 9'h000;
    req = 1;
    tick(); chk("t2_start", pc, 0); chk("t2_cnt0", icount, 0);
    repeat (5) tick();
    chk("t2_pc5", pc, 5);
    jump(10'd40); chk("t2_abs", pc, 40);
    jump(10'd5); chk("t2_back", pc, 5);
    branch = 1; taken = 0; how_high = 1; br_target = 10'd40;
    tick(); chk("t2_nottaken", pc, 6);
    jump(10'd3); chk("t3_pc3", pc, 3);
    branch = 1; taken = 1; how_high = 0; br_offset = 8'hFB;
    tick(); chk("t3_relwrap", pc, 1022);
    branch = 0; taken = 0;
    tick(); chk("t3_pc1023", pc, 1023);
    tick(); chk("t3_wrap0", pc, 0);
    branch = 1; taken = 1; br_offset = 8'h05;
    tick(); chk("t3_relpos", pc, 5);
    branch = 0; taken = 0;
    rom[7] = 9'h1FF;
    jump(10'd7); chk("t4_pc7", pc, 7); chk("t4_cnt", icount, 14);
    stall = 1; branch = 1; taken = 1; how_high = 1; br_target = 10'd40;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("t4_stall_pc", pc, 7); chk("t4_stall_cnt", icount, 14); chk("t4_stall_done", done, 0);
    end
    stall = 0;
    tick(); chk("t4_done", done, 1); chk("t4_pc_hold", pc, 7); chk("t4_cnt_halt", icount, 15);
    branch = 0; taken = 0; how_high = 0; stall = 1;
    tick(); chk("t4_done_stall_ign", done, 1);
    stall = 0; req = 0;
    tick(); chk("t4_idle", done, 0);
    rom[7] = 9'h000;
    req = 1;
    tick(); chk("t5_start", running, 1);
    repeat (12) tick();
    chk("t5_pc12", pc, 12); chk("t5_cnt12", icount, 12);
    #2 rst = 1;
    #1 chk("t5_rst_pc", pc, 0); chk("t5_rst_run", running, 0); chk("t5_rst_cnt", icount, 0); chk("t5_rst_done", done, 0);
    tick(); rst = 0;
    tick(); chk("t5_restart_run", running, 1); chk("t5_restart_pc", pc, 0); chk("t5_restart_cnt", icount, 0);
    tick(); chk("t6_pc1", pc, 1);
    rom[25] = 9'h1FF;
    repeat (14) tick();
    chk("t6_pc15", pc, 15); chk("t6_cnt15", icount, 15);
    tick(); chk("t6_pc16", pc, 16); chk("t6_sat", icount, 15);
    repeat (9) tick();
    chk("t6_pc25", pc, 25);
    tick(); chk("t6_done", done, 1); chk("t6_cnt_sat", icount, 15); chk("t6_pc_hold", pc, 25);
    repeat (2) tick();
    chk("t6_done_hold", done, 1); chk("t6_no_rerun", running, 0);
    req = 0;
    tick(); chk("t6_idle", done, 0);
    req = 1;
    tick(); chk("t6_rerun", running, 1); chk("t6_rerun_pc", pc, 0); chk("t6_rerun_cnt", icount, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
